// File: rtl/lc3b_pkg.sv
// Shared LC-3b types: machine word, register index and general-purpose register count.
package lc3b_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_idx_t;

  localparam int unsigned NUM_GPR = 8;

endpackage

// File: rtl/reg_file_gpr.sv
// One general-purpose register: synchronous active-high clear, load enable.
module gpr_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) q_d = d_i;
  end

  // Clear wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_file.sv
// LC-3b register file: one synchronous write port, two combinational read ports, no bypass.
module reg_file
  import lc3b_pkg::*;
#(
  parameter int unsigned DATA_W = $bits(word_t),
  parameter int unsigned ADDR_W = $bits(reg_idx_t)
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] data,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] DR,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2_OUT,
  input  logic              reset
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0]   ld_c;
  logic [DATA_W-1:0] regs_c [NREG];

  // One-hot load enable for the destination register.
  always_comb begin
    ld_c = '0;
    if (LD_REG) ld_c[DR] = 1'b1;
  end

  for (genvar g = 0; g < NREG; g++) begin : g_gpr
    gpr_reg #(.W(DATA_W)) u_gpr (
      .clk   (clk),
      .reset (reset),
      .ld_i  (ld_c[g]),
      .d_i   (data),
      .q_o   (regs_c[g])
    );
  end

  assign SR1_OUT = regs_c[SR1];
  assign SR2_OUT = regs_c[SR2];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: driver queues expected reads from an array model, monitor compares.
module tb_reg_file;

  logic        clk = 1'b0;
  logic [15:0] data;
  logic        LD_REG;
  logic        reset;
  logic [2:0]  DR;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_OUT;

  always #5 clk = ~clk;

  reg_file dut (
    .clk     (clk),
    .data    (data),
    .LD_REG  (LD_REG),
    .DR      (DR),
    .SR1     (SR1),
    .SR2     (SR2),
    .SR1_OUT (SR1_OUT),
    .SR2_OUT (SR2_OUT),
    .reset   (reset)
  );

  typedef struct {
    logic [15:0] e1;
    logic [15:0] e2;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [8];
  bit          chk_v = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Drive one cycle; expected reads are the register contents before the coming edge.
  task automatic cyc(input bit rst, input bit ld, input logic [2:0] dr, input logic [15:0] d,
                     input logic [2:0] s1, input logic [2:0] s2, input bit chk, input string tag);
    exp_t e;
    reset  = rst;
    LD_REG = ld;
    DR     = dr;
    data   = d;
    SR1    = s1;
    SR2    = s2;
    chk_v  = chk;
    if (chk) begin
      e.e1  = model[s1];
      e.e2  = model[s2];
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (ld) begin
      model[dr] = d;
    end
    #1;
  endtask

  task automatic rd(input logic [2:0] s1, input logic [2:0] s2, input string tag);
    cyc(1'b0, 1'b0, 3'd0, 16'h0000, s1, s2, 1'b1, tag);
  endtask

  // Monitor: reads are combinational, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_v) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: read presented with no expected entry");
      end else begin
        e = sb.pop_front();
        if (SR1_OUT !== e.e1 || SR2_OUT !== e.e2) begin
          n_bad++;
          $display("FAIL %s: SR1=%0d SR2=%0d got %h/%h expected %h/%h",
                   e.tag, SR1, SR2, SR1_OUT, SR2_OUT, e.e1, e.e2);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, "");

    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i), "reset_sweep");

    cyc(1'b0, 1'b1, 3'd3, 16'h0069, 3'd0, 3'd0, 1'b0, "");
    rd(3'd3, 3'd3, "basic_write");
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(i), "basic_others");

    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 3'(i), 16'h1110 + 16'(i), 3'd0, 3'd0, 1'b0, "");
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i), "all_regs");

    cyc(1'b0, 1'b1, 3'd5, 16'h5555, 3'd0, 3'd0, 1'b0, "");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 3'd5, 16'hBEEF, 3'd5, 3'd4, 1'b1, "write_disabled");
    rd(3'd5, 3'd5, "write_disabled_after");

    cyc(1'b0, 1'b1, 3'd2, 16'h1234, 3'd0, 3'd0, 1'b0, "");
    cyc(1'b0, 1'b1, 3'd2, 16'hABCD, 3'd2, 3'd2, 1'b1, "rw_before_edge");
    rd(3'd2, 3'd2, "rw_after_edge");

    cyc(1'b1, 1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd0, 1'b1, "reset_prio_pre");
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(i), "reset_prio");

    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, "random");

    cyc(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, "");
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file for the LC-3b CPU: eight 16-bit registers R0–R7 with one synchronous write port and two combinational read ports. The decode/execute datapath inside `LC3` uses it to source ALU operands (SR1, SR2) and to receive results (DR). It is clocked by the CPU clock `clk` and cleared by the CPU reset.

## Interface
Parameters:
- `DATA_W`, default 16: register and port data width.
- `ADDR_W`, default 3: register index width; register count is 2^ADDR_W (8).

Ports (name, direction, width, meaning):
- `clk`, input, 1: CPU clock. All state changes occur on its rising edge.
- `reset`, input, 1: synchronous, active-high reset; clears all registers.
- `data`, input, DATA_W: write data.
- `LD_REG`, input, 1: write enable.
- `DR`, input, ADDR_W: destination register index.
- `SR1`, input, ADDR_W: read port 1 register index.
- `SR2`, input, ADDR_W: read port 2 register index.
- `SR1_OUT`, output, DATA_W: contents of register `SR1`.
- `SR2_OUT`, output, DATA_W: contents of register `SR2`.
- Declaration order: `clk, data, LD_REG, DR, SR1, SR2, SR1_OUT, SR2_OUT, reset`. Reset is declared last so that existing positional instances remain valid.

## Operation
- Storage: 8 × 16-bit registers. R0 is an ordinary writable register and is not hardwired to zero.
- Write: on a rising edge of `clk`, when `reset`=0 and `LD_REG`=1, register[`DR`] <= `data`. When `LD_REG`=0, no register changes.
- Read: `SR1_OUT` = register[`SR1`] and `SR2_OUT` = register[`SR2`], both purely combinational. There is no output register.
- `SR1` and `SR2` may select the same register, and either may equal `DR`. There are no restrictions on these combinations.
- No write-through bypass: a read of `DR` during a write cycle returns the old value until the edge, then the new value.
- Reset: on a rising edge with `reset`=1, all eight registers become 0x0000. Reset overrides a simultaneous write. After reset, both outputs read 0x0000 for any index.
- X or Z on `SR1`/`SR2` may produce X outputs. X on `DR` while `LD_REG`=1 is not supported.

## Timing
- Write latency: 1 clock. Data is visible on the read ports after the rising edge plus combinational delay.
- Read latency: 0 clocks, combinational from `SR1`/`SR2` and register state.
- Reset latency: 1 clock. Asserting reset mid-sequence discards every prior write at that edge.
- Outputs are defined only after the first reset edge. Before that, register contents are don't-care and simulation may show X.

## Structure
- Shared package `lc3b_pkg`:
  - `word_t` (logic [15:0])
  - `reg_idx_t` (logic [2:0])
  - `NUM_GPR = 8`
- Storage is an array of `word_t`, with a write-decode loop and two read multiplexers.
- One sub-module is natural: `gpr_reg`, a single 16-bit register with synchronous reset and load enable, instantiated 8 times with per-register enables decoded from `DR`/`LD_REG`.

## Test plan
- Reset: assert `reset` for 1 edge. Sweep `SR1`/`SR2` over 0–7 -> every read is 0x0000.
- Basic write: `data`=0x0069, `DR`=3, `LD_REG`=1 for one edge, then `LD_REG`=0. `SR1`=3 -> `SR1_OUT`=0x0069. `SR2`=3 -> `SR2_OUT`=0x0069. Other indices -> 0x0000.
- All registers: write 0x1110+i to Ri for i=0..7. Read each on both ports -> values match exactly, including R0=0x1110.
- Write disabled: `LD_REG`=0, `DR`=5, `data`=0xBEEF for several edges -> R5 is unchanged.
- Same-cycle read/write: R2=0x1234, then `DR`=`SR1`=2, `data`=0xABCD, `LD_REG`=1 -> `SR1_OUT`=0x1234 before the edge and 0xABCD after it.
- Reset priority: `reset`=1 and `LD_REG`=1 (`DR`=7, `data`=0xFFFF) on the same edge -> R7=0x0000 and all other registers are 0x0000.
